muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M/RV64M multiply-divide unit; successor to the combinational ALU decoder.
//  Decodes funct3/funct7 of OP-type instructions, flags M-extension ops and executes them over multiple cycles.
//  Sits beside the ALU in the execute stage; the core stalls on req_ready/rsp_valid.
// PARAMETERS
//  XLEN        32  operand/result width (32 or 64)
//  EARLY_OUT   1   1: div-by-zero and signed-overflow cases finish in 1 cycle; 0: run full iteration
// PORTS
//  clk         in   1     clock, rising edge
//  reset_n     in   1     reset, asynchronous, active-low
//  opb5        in   1     instr[5]; 1 = register-register op
//  funct3      in   3     instr[14:12]
//  funct7      in   7     instr[31:25]
//  is_muldiv   out  1     comb: opb5 & funct7==7'b0000001
//  req_valid   in   1     start request (operands/funct3 valid)
//  req_ready   out  1     unit idle, accepts request
//  rs1, rs2    in   XLEN  operands
//  flush       in   1     abort in-flight op, return to IDLE
//  rsp_valid   out  1     result available
//  rsp_ready   in   1     consumer takes result
//  result      out  XLEN  product/quotient/remainder
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, result=0, counter=0, all datapath regs 0.
//  Accept when req_valid & req_ready & is_muldiv; operands/op latched that edge.
//  Op decode (funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  FSM: IDLE -> MUL (funct3[2]=0) | DIV (funct3[2]=1) | DONE (special case, EARLY_OUT=1).
//   MUL: shift-add on |operands| per signedness, 1 bit/cycle, XLEN cycles, 2*XLEN-bit accumulator.
//   DIV: restoring divide on magnitudes, 1 bit/cycle, XLEN cycles.
//   FIX: 1 cycle sign correction & result select -> DONE.
//   DONE: rsp_valid=1, result stable; on rsp_ready -> IDLE (req_ready=1 next cycle; no same-cycle re-accept).
//  Latency accept->rsp_valid: XLEN+2 cycles normal; 1 cycle for early-out cases.
//  Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
//  Result select: MUL low XLEN bits; MULH* high XLEN bits of 2*XLEN product.
//  Sign fix: quotient negated if signs differ (signed ops); remainder takes dividend sign.
//  Divide by zero: quotient = all ones, remainder = rs1 (signed and unsigned).
//  Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, DIV/REM): quotient = rs1, remainder = 0.
//  flush: any state -> IDLE next edge; rsp_valid drops; flush beats a same-cycle accept.
//  rsp_valid held with result unchanged until rsp_ready; rs1/rs2 changes ignored while busy.
//  reset_n low mid-operation: immediate return to reset values, no partial result emitted.
//  Non-M request (is_muldiv=0) with req_valid: ignored, state unchanged.
// STRUCTURE
//  Shared package defs_pkg: md_op_t enum (8 ops above), md_state_t {IDLE,MUL,DIV,FIX,DONE},
//   FUNCT7_MULDIV = 7'b0000001.
//  Sub-module muldiv_dec: combinational funct3/funct7/opb5 -> {is_muldiv, md_op_t, signed flags}.
//  Top holds FSM, log2(XLEN)+1-bit counter, shared XLEN+1-bit adder/subtractor for both loops.
// TESTING (XLEN=32)
//  MUL 7 * -3 -> result 0xFFFFFFEB after 34 cycles; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, rsp_valid 1 cycle after accept; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  rsp_ready low 5 cycles -> rsp_valid and result held; flush at cycle 10 of DIV -> IDLE, req_ready=1 next cycle.
//  reset_n pulsed low mid-MUL -> all outputs at reset values asynchronously; funct7=0 request -> ignored.

Source files
------------

// File: rtl/defs_pkg.sv
// rtl/defs_pkg.sv - shared op/state types for the multiply-divide unit
package defs_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } md_state_t;

  // Divide family (quotient or remainder) versus multiply family
  function automatic logic op_is_div(md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Ops that return the quotient rather than the remainder
  function automatic logic op_is_quot(md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_dec.sv
// rtl/muldiv_dec.sv - combinational M-extension decode of funct3/funct7/opb5
module muldiv_dec
  import defs_pkg::*;
(
  input  logic       opb5_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       is_muldiv_o,
  output md_op_t     op_o,
  output logic       signed_a_o,
  output logic       signed_b_o
);

  // Op class and operand signedness; MUL is marked signed but its low half is sign-agnostic
  always_comb begin
    is_muldiv_o = opb5_i && (funct7_i == FUNCT7_MULDIV);
    op_o        = md_op_t'(funct3_i);
    signed_a_o  = 1'b0;
    signed_b_o  = 1'b0;
    case (op_o)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        signed_a_o = 1'b1;
        signed_b_o = 1'b1;
      end
      OP_MULHSU: signed_a_o = 1'b1;
      default: begin
        signed_a_o = 1'b0;
        signed_b_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply-divide unit
module muldiv_unit
  import defs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            is_muldiv,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_q;
  md_op_t          op_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_quot_q, neg_rem_q, div_zero_q;
  logic            req_ready_q, rsp_valid_q;

  md_op_t          dec_op;
  logic            dec_signed_a, dec_signed_b;

  logic            a_neg, b_neg, div_zero, div_ovf, early;
  logic [XLEN-1:0] a_mag, b_mag, early_res;
  logic [XLEN:0]   add_a, add_b, add_res;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  muldiv_dec u_dec (
    .opb5_i      (opb5),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .is_muldiv_o (is_muldiv),
    .op_o        (dec_op),
    .signed_a_o  (dec_signed_a),
    .signed_b_o  (dec_signed_b)
  );

  // Operand magnitudes and the single-cycle divide special cases, evaluated at accept
  always_comb begin
    a_neg     = dec_signed_a && rs1[XLEN-1];
    b_neg     = dec_signed_b && rs2[XLEN-1];
    a_mag     = a_neg ? -rs1 : rs1;
    b_mag     = b_neg ? -rs2 : rs2;
    div_zero  = (rs2 == '0);
    div_ovf   = dec_signed_a && (rs1 == MIN_NEG) && (rs2 == '1);
    early     = EARLY_OUT && op_is_div(dec_op) && (div_zero || div_ovf);
    early_res = '0;
    if (op_is_quot(dec_op)) early_res = div_zero ? '1 : rs1;
    else                    early_res = div_zero ? rs1 : '0;
  end

  // Shared adder: accumulate multiplicand in MUL, trial-subtract divisor in DIV
  always_comb begin
    if (state_q == DIV) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = {1'b0, b_q};
      add_res = add_a - add_b;
    end else begin
      add_a   = {1'b0, hi_q};
      add_b   = lo_q[0] ? {1'b0, b_q} : '0;
      add_res = add_a + add_b;
    end
  end

  // One iteration step; in DIV the adder's top bit is the borrow (shifted remainder < divisor)
  always_comb begin
    if (state_q == DIV) begin
      hi_d = add_res[XLEN] ? add_a[XLEN-1:0] : add_res[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~add_res[XLEN]};
    end else begin
      hi_d = add_res[XLEN:1];
      lo_d = {add_res[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction and result select; divide-by-zero quotient forced to all ones
  always_comb begin
    prod_fix = neg_quot_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_fix = div_zero_q ? '1 : (neg_quot_q ? -lo_q : lo_q);
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quot_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  // Control FSM plus datapath registers; flush overrides everything including an accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q && is_muldiv) begin
            op_q        <= dec_op;
            hi_q        <= '0;
            lo_q        <= a_mag;
            b_q         <= b_mag;
            cnt_q       <= '0;
            neg_quot_q  <= a_neg ^ b_neg;
            neg_rem_q   <= a_neg;
            div_zero_q  <= div_zero;
            req_ready_q <= 1'b0;
            if (early) begin
              result_q    <= early_res;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= op_is_div(dec_op) ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_q <= FIX;
        end
        FIX: begin
          result_q    <= fix_res;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (XLEN=32)
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        opb5;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_muldiv;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  logic prev_valid = 1'b0;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opb5      (opb5),
    .funct3    (funct3),
    .funct7    (funct7),
    .is_muldiv (is_muldiv),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference results straight from the RISC-V M arithmetic definitions
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa) * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (f3[2] && (b == 32'd0 || ovf)) return 1;
    return 34;
  endfunction

  // Compare process: every cycle a response is presented it must match the head of the queue
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        if (!prev_valid) check("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
        check("result", 64'(result), 64'(exp_q[0].res));
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input int hold);
    exp_t e;
    logic got;
    check("model_pin", 64'(model(f3, a, b)), 64'(lit));
    e.res = model(f3, a, b);
    e.lat = exp_latency(f3, a, b);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = f3; funct7 = 7'b0000001; opb5 = 1'b1; rs1 = a; rs2 = b;
    @(negedge clk);
    acc_cyc = cyc;
    check("accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("rsp_arrived", 64'(got), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_held", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    check("drop_valid", 64'(rsp_valid), 64'd0);
    check("ready_after", 64'(req_ready), 64'd1);
  endtask

  task automatic expect_quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; opb5 = 1'b1; funct3 = 3'd0; funct7 = 7'b0000001;
    req_valid = 1'b0; rs1 = '0; rs2 = '0; flush = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Decode of the M-extension flag
    opb5 = 1'b1; funct7 = 7'b0000001; #1; check("dec_m", 64'(is_muldiv), 64'd1);
    opb5 = 1'b0; funct7 = 7'b0000001; #1; check("dec_opb5", 64'(is_muldiv), 64'd0);
    opb5 = 1'b1; funct7 = 7'b0000000; #1; check("dec_f7_0", 64'(is_muldiv), 64'd0);
    opb5 = 1'b1; funct7 = 7'b0100001; #1; check("dec_f7_21", 64'(is_muldiv), 64'd0);
    funct7 = 7'b0000001;

    do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    do_op(3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 0);
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        0);
    do_op(3'd7, 32'd100,       32'd7,         32'd2,         0);
    do_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'd5,         32'd0,         32'd5,         3);
    do_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

    // Flush in the middle of a divide
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'(req_ready), 64'd1);
    check("flush_valid", 64'(rsp_valid), 64'd0);
    expect_quiet("flush_quiet", 40);

    // Flush wins over a same-cycle accept (early-out op would respond next cycle)
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'd4; rs1 = 32'd5; rs2 = 32'd0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_acc_valid", 64'(rsp_valid), 64'd0);
    check("flush_acc_ready", 64'(req_ready), 64'd1);
    expect_quiet("flush_acc_quiet", 5);

    // Non-M request ignored
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'd4; funct7 = 7'b0000000; rs1 = 32'd5; rs2 = 32'd0;
    @(negedge clk);
    check("nonm_flag", 64'(is_muldiv), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; funct7 = 7'b0000001;
    @(negedge clk);
    check("nonm_ready", 64'(req_ready), 64'd1);
    expect_quiet("nonm_quiet", 5);

    // Asynchronous reset in the middle of a multiply; last result above is non-zero
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    expect_quiet("arst_quiet", 40);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
